inst_timing: RTL
================

INST_TIMING -- requirements
Module: inst_timing

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates occur on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port data_in, input, 8 bits: data bus, carrying the opcode during the fetch cycle.
REQ-004 SHALL have port dec_len, input, 3 bits: base cycle count of the latched opcode, from the external decoder.
REQ-005 SHALL have port dec_pgx, input, 1 bit: opcode takes one extra cycle on a page cross.
REQ-006 SHALL have port dec_branch, input, 1 bit: opcode is a conditional branch.
REQ-007 SHALL have port page_cross, input, 1 bit: the datapath address adder carried into the high byte.
REQ-008 SHALL have port branch_taken, input, 1 bit: the branch condition is true.
REQ-009 SHALL have port nmi_n, input, 1 bit: NMI request, falling-edge sensitive.
REQ-010 SHALL have port irq_n, input, 1 bit: IRQ request, level sensitive.
REQ-011 SHALL have port i_flag, input, 1 bit: interrupt-disable flag from the status register.
REQ-012 SHALL have port next_sync, output, 1 bit: combinational; high in the final cycle of an instruction; drives the instruction sequencer.
REQ-013 SHALL have port opcode, output, 8 bits: registered, latched instruction.
REQ-014 SHALL have port cyc_num, output, 3 bits: registered binary cycle index; 0 in the fetch cycle.
REQ-015 SHALL have port vector_sel, output, 2 bits: 00 none, 01 RESET, 10 NMI, 11 IRQ/BRK.
REQ-016 SHALL have port brk_flag, output, 1 bit: high during a software BRK sequence (B flag value to push).

Function
REQ-017 SHALL hold an internal sync_q, equal to next_sync registered; sync_q=1 marks the fetch cycle (cyc_num=0).
REQ-018 SHALL update cyc_num to 0 when next_sync=1; otherwise cyc_num increments, saturating at 7.
REQ-019 SHALL compute instruction length L:
- L=7 when vector_sel!=00 or brk_flag=1.
- Otherwise L=max(dec_len,2) + (dec_pgx&page_cross) + (dec_branch&branch_taken) + (dec_branch&branch_taken&page_cross).
- L is capped at 8.
REQ-020 SHALL assert next_sync exactly when cyc_num==L-1; it is never asserted at cyc_num=0.
REQ-021 SHALL require the datapath to hold page_cross and branch_taken stable from the cycle they become valid until next_sync; the block does not register them.
REQ-022 SHALL, at the clock edge ending a fetch cycle, load opcode from data_in when take_int=0, or load 8'h00 when take_int=1.
REQ-023 SHALL detect NMI edges:
- Register nmi_n into nmi_q, reset value 1.
- A cycle with nmi_q=1 and nmi_n=0 sets nmi_pend.
REQ-024 SHALL define irq_req = !irq_n & !i_flag, sampled combinationally.
REQ-025 SHALL register take_int <= nmi_pend|irq_req, and int_kind <= NMI if nmi_pend else IRQ, on the edge where next_sync=1; take_int is cleared at the end of the fetch cycle.
REQ-026 SHALL, at the end of a fetch cycle with take_int=1, set vector_sel=int_kind and brk_flag=0.
REQ-027 SHALL clear nmi_pend at the end of the fetch cycle that begins an NMI sequence; a new falling edge in that same cycle keeps nmi_pend set (set wins).
REQ-028 SHALL, at the end of a fetch cycle with take_int=0 and data_in=8'h00, set vector_sel=11 and brk_flag=1.
REQ-029 SHALL, at the end of any other fetch cycle, clear vector_sel to 00 and brk_flag to 0.
REQ-030 SHALL keep NMI priority over IRQ; an edge arriving during any sequence, including an interrupt sequence, is serviced at the next instruction boundary.
REQ-031 SHALL keep the IRQ level-only: irq_req deasserting before the next_sync edge cancels the service.

Reset
REQ-032 SHALL, while rst_n=0 at a clock edge, load: cyc_num=0, opcode=8'h00, vector_sel=01, brk_flag=0, nmi_pend=0, nmi_q=1, take_int=0, sync_q=0.
REQ-033 SHALL, after release, run a 7-cycle RESET sequence: next_sync high at cyc_num=6, then a normal fetch with vector_sel cleared at the end of that fetch.
REQ-034 SHALL, on reset asserted mid-instruction, abandon the instruction and discard pending NMI/IRQ.

Verification
REQ-035 SHALL cover: release reset, data_in=8'hEA, dec_len=2 -> next_sync at cyc_num 6; opcode=EA after the fetch; next_sync again at cyc_num 1; vector_sel 01 then 00.
REQ-036 SHALL cover: dec_len=4, dec_pgx=1, page_cross=1 -> next_sync at cyc_num 4; with page_cross=0 -> at cyc_num 3.
REQ-037 SHALL cover: branch with dec_len=2 -> next_sync at cyc_num 1 (not taken), 2 (taken), 3 (taken + page_cross).
REQ-038 SHALL cover: irq_n=0, i_flag=0 during a 3-cycle instruction -> next fetch loads opcode 00, vector_sel=11, brk_flag=0, 7 cycles; with i_flag=1 -> no interrupt.
REQ-039 SHALL cover: nmi_n falling edge together with irq_n=0 -> NMI sequence first (vector_sel=10), then IRQ; nmi_n held low -> no second NMI.
REQ-040 SHALL cover: data_in=8'h00 fetched with no interrupt pending -> brk_flag=1, vector_sel=11, next_sync at cyc_num 6.

Source files
------------

// File: rtl/inst_timing.sv
// Instruction timing and interrupt sequencing for a 6502-style core: tracks the
// cycle index within each instruction, flags its final cycle and arbitrates NMI/IRQ/BRK/RESET.
module inst_timing (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic [2:0] dec_len,
  input  logic       dec_pgx,
  input  logic       dec_branch,
  input  logic       page_cross,
  input  logic       branch_taken,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       i_flag,
  output logic       next_sync,
  output logic [7:0] opcode,
  output logic [2:0] cyc_num,
  output logic [1:0] vector_sel,
  output logic       brk_flag
);

  localparam logic [1:0] VEC_NONE  = 2'b00;
  localparam logic [1:0] VEC_RESET = 2'b01;
  localparam logic [1:0] VEC_NMI   = 2'b10;
  localparam logic [1:0] VEC_IRQ   = 2'b11;

  localparam logic [3:0] LEN_MIN = 4'd2;
  localparam logic [3:0] LEN_MAX = 4'd8;
  localparam logic [3:0] LEN_SEQ = 4'd7;

  logic       sync_q,       sync_d;
  logic [2:0] cyc_num_q,    cyc_num_d;
  logic [7:0] opcode_q,     opcode_d;
  logic [1:0] vector_sel_q, vector_sel_d;
  logic       brk_flag_q,   brk_flag_d;
  logic       nmi_q,        nmi_d;
  logic       nmi_pend_q,   nmi_pend_d;
  logic       take_int_q,   take_int_d;
  logic       int_nmi_q,    int_nmi_d;

  logic       br_taken;
  logic       irq_req;
  logic       nmi_fall;
  logic [3:0] base_len;
  logic [3:0] raw_len;
  logic [3:0] inst_len;

  // Length of the current instruction; page_cross/branch_taken are used live.
  always_comb begin
    br_taken = dec_branch & branch_taken;
    base_len = ({1'b0, dec_len} < LEN_MIN) ? LEN_MIN : {1'b0, dec_len};
    raw_len  = base_len
             + {3'b000, dec_pgx & page_cross}
             + {3'b000, br_taken}
             + {3'b000, br_taken & page_cross};
    if ((vector_sel_q != VEC_NONE) || brk_flag_q) begin
      inst_len = LEN_SEQ;
    end else if (raw_len > LEN_MAX) begin
      inst_len = LEN_MAX;
    end else begin
      inst_len = raw_len;
    end
  end

  always_comb begin
    next_sync = (cyc_num_q != 3'd0) && ({1'b0, cyc_num_q} == (inst_len - 4'd1));
    irq_req   = ~irq_n & ~i_flag;
    nmi_fall  = nmi_q & ~nmi_n;
  end

  always_comb begin
    sync_d       = next_sync;
    cyc_num_d    = cyc_num_q;
    opcode_d     = opcode_q;
    vector_sel_d = vector_sel_q;
    brk_flag_d   = brk_flag_q;
    nmi_d        = nmi_n;
    nmi_pend_d   = nmi_pend_q;
    take_int_d   = take_int_q;
    int_nmi_d    = int_nmi_q;

    if (next_sync) begin
      cyc_num_d = 3'd0;
    end else if (cyc_num_q != 3'd7) begin
      cyc_num_d = cyc_num_q + 3'd1;
    end

    // sync_q marks the fetch cycle; its closing edge decides what the next sequence is.
    if (sync_q) begin
      take_int_d = 1'b0;
      brk_flag_d = 1'b0;
      if (take_int_q) begin
        opcode_d     = 8'h00;
        vector_sel_d = int_nmi_q ? VEC_NMI : VEC_IRQ;
      end else if (data_in == 8'h00) begin
        opcode_d     = 8'h00;
        vector_sel_d = VEC_IRQ;
        brk_flag_d   = 1'b1;
      end else begin
        opcode_d     = data_in;
        vector_sel_d = VEC_NONE;
      end
    end

    if (next_sync) begin
      take_int_d = nmi_pend_q | irq_req;
      int_nmi_d  = nmi_pend_q;
    end

    // A fresh falling edge beats the clear from an NMI sequence starting.
    if (nmi_fall) begin
      nmi_pend_d = 1'b1;
    end else if (sync_q && take_int_q && int_nmi_q) begin
      nmi_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q       <= 1'b0;
      cyc_num_q    <= 3'd0;
      opcode_q     <= 8'h00;
      vector_sel_q <= VEC_RESET;
      brk_flag_q   <= 1'b0;
      nmi_q        <= 1'b1;
      nmi_pend_q   <= 1'b0;
      take_int_q   <= 1'b0;
      int_nmi_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      cyc_num_q    <= cyc_num_d;
      opcode_q     <= opcode_d;
      vector_sel_q <= vector_sel_d;
      brk_flag_q   <= brk_flag_d;
      nmi_q        <= nmi_d;
      nmi_pend_q   <= nmi_pend_d;
      take_int_q   <= take_int_d;
      int_nmi_q    <= int_nmi_d;
    end
  end

  assign opcode     = opcode_q;
  assign cyc_num    = cyc_num_q;
  assign vector_sel = vector_sel_q;
  assign brk_flag   = brk_flag_q;

endmodule
